// File: rtl/gpmc_bus_pkg.sv
// Shared types and constants for the GPMC bus controller.
// Optional ack timeout is enabled with `define GPMC_BUS_TIMEOUT_EN.
package gpmc_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WR_SETTLE = 2'd1,
        S_REQ       = 2'd2,
        S_DONE      = 2'd3
    } gpmc_state_t;

    // Wide enough for any supported DATA_WIDTH; sliced at the point of use.
    localparam logic [63:0] ERR_WORD = '1;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/gpmc_addr_decode.sv
// Combinational host address decode: slave select, local address and miss flag.
module gpmc_addr_decode
    import gpmc_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned NUM_SLAVES      = 4,
    parameter int unsigned SLAVE_ADDR_BITS = 12,
    parameter int unsigned SEL             = $clog2(NUM_SLAVES)
) (
    input  logic [ADDR_WIDTH-1:0]      i_address,
    output logic [NUM_SLAVES-1:0]      o_sel,
    output logic [SEL-1:0]             o_idx,
    output logic [SLAVE_ADDR_BITS-1:0] o_local_addr,
    output logic                       o_miss
);

    always_comb begin
        o_miss       = 1'b0;
        o_idx        = i_address[SLAVE_ADDR_BITS +: SEL];
        o_local_addr = i_address[SLAVE_ADDR_BITS-1:0];
        o_sel        = '0;
        // Any set bit above the slave-select field is outside the decoded window.
        for (int unsigned i = SLAVE_ADDR_BITS + SEL; i < ADDR_WIDTH; i++) begin
            o_miss = o_miss | i_address[i];
        end
        if (!o_miss) begin
            o_sel[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/gpmc_bus_ctrl.sv
// Converts level-style GPMC host strobes into one-shot req/ack slave transactions.
// Optional ack timeout: `define GPMC_BUS_TIMEOUT_EN.
module gpmc_bus_ctrl
    import gpmc_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned NUM_SLAVES      = 4,
    parameter int unsigned SLAVE_ADDR_BITS = 12,
    parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             host_csn,
    input  logic                             host_oen,
    input  logic                             host_wen,
    input  logic [ADDR_WIDTH-1:0]            host_address,
    input  logic [DATA_WIDTH-1:0]            host_wdata,
    output logic [DATA_WIDTH-1:0]            host_rdata,
    output logic [NUM_SLAVES-1:0]            slv_req,
    output logic                             slv_we,
    output logic [SLAVE_ADDR_BITS-1:0]       slv_addr,
    output logic [DATA_WIDTH-1:0]            slv_wdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata,
    input  logic [NUM_SLAVES-1:0]            slv_ack,
    input  logic                             err_clear,
    output logic                             bus_error,
    output logic                             busy
);

    localparam int unsigned SEL = $clog2(NUM_SLAVES);

    gpmc_state_t                r_state;
    logic [NUM_SLAVES-1:0]      r_req;
    logic                       r_we;
    logic [SLAVE_ADDR_BITS-1:0] r_addr;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [DATA_WIDTH-1:0]      r_rdata;
    logic [SEL-1:0]             r_idx;
    logic                       r_err;

    logic [NUM_SLAVES-1:0]      w_sel;
    logic [SEL-1:0]             w_idx;
    logic [SLAVE_ADDR_BITS-1:0] w_local;
    logic                       w_miss;
    logic                       w_rd_launch;
    logic                       w_launch;

`ifdef GPMC_BUS_TIMEOUT_EN
    localparam int unsigned TMO_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] r_tmo;
`endif

    gpmc_addr_decode #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .NUM_SLAVES      (NUM_SLAVES),
        .SLAVE_ADDR_BITS (SLAVE_ADDR_BITS),
        .SEL             (SEL)
    ) u_decode (
        .i_address    (host_address),
        .o_sel        (w_sel),
        .o_idx        (w_idx),
        .o_local_addr (w_local),
        .o_miss       (w_miss)
    );

    // Reads launch straight from IDLE; writes launch one cycle later from WR_SETTLE.
    always_comb begin
        w_rd_launch = (r_state == S_IDLE) && !host_csn && !host_oen && host_wen;
        w_launch    = w_rd_launch || (r_state == S_WR_SETTLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_req   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
`ifdef GPMC_BUS_TIMEOUT_EN
            r_tmo   <= '0;
`endif
        end else begin
            // Error sets later in this block override the clear.
            if (err_clear) begin
                r_err <= 1'b0;
            end

            if (w_launch) begin
                r_addr  <= w_local;
                r_wdata <= host_wdata;
                r_we    <= (r_state == S_WR_SETTLE);
                r_idx   <= w_idx;
`ifdef GPMC_BUS_TIMEOUT_EN
                r_tmo   <= '0;
`endif
                if (w_miss) begin
                    r_rdata <= ERR_WORD[DATA_WIDTH-1:0];
                    r_err   <= 1'b1;
                    r_state <= S_DONE;
                end else begin
                    r_req   <= w_sel;
                    r_state <= S_REQ;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!host_csn && !host_oen && !host_wen) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else if (!host_csn && !host_wen) begin
                            r_state <= S_WR_SETTLE;
                        end
                    end
                    S_REQ: begin
                        if (slv_ack[r_idx]) begin
                            r_req <= '0;
                            if (!r_we) begin
                                r_rdata <= slv_rdata[r_idx*DATA_WIDTH +: DATA_WIDTH];
                            end
                            r_state <= S_DONE;
                        end
`ifdef GPMC_BUS_TIMEOUT_EN
                        else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                            r_req <= '0;
                            if (!r_we) begin
                                r_rdata <= ERR_WORD[DATA_WIDTH-1:0];
                            end
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
`endif
                    end
                    S_DONE: begin
                        if (host_csn || (host_oen && host_wen)) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign host_rdata = r_rdata;
    assign slv_req    = r_req;
    assign slv_we     = r_we;
    assign slv_addr   = r_addr;
    assign slv_wdata  = r_wdata;
    assign bus_error  = r_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_gpmc_bus_ctrl.sv
// Directed-vector bench for gpmc_bus_ctrl; timeout checks follow GPMC_BUS_TIMEOUT_EN.
module tb_gpmc_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        host_csn, host_oen, host_wen;
    logic [15:0] host_address;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic [3:0]  slv_req;
    logic        slv_we;
    logic [11:0] slv_addr;
    logic [15:0] slv_wdata;
    logic [63:0] slv_rdata;
    logic [3:0]  slv_ack;
    logic        err_clear;
    logic        bus_error;
    logic        busy;

    logic [3:0]  ack_en;
    logic [3:0]  ack_force;
    logic [3:0]  r_ack_q;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    gpmc_bus_ctrl #(
        .ADDR_WIDTH      (16),
        .DATA_WIDTH      (16),
        .NUM_SLAVES      (4),
        .SLAVE_ADDR_BITS (12),
        .TIMEOUT_CYCLES  (255)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .host_csn     (host_csn),
        .host_oen     (host_oen),
        .host_wen     (host_wen),
        .host_address (host_address),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .slv_req      (slv_req),
        .slv_we       (slv_we),
        .slv_addr     (slv_addr),
        .slv_wdata    (slv_wdata),
        .slv_rdata    (slv_rdata),
        .slv_ack      (slv_ack),
        .err_clear    (err_clear),
        .bus_error    (bus_error),
        .busy         (busy)
    );

    // Slaves answer one cycle after seeing req; ack_force injects unsolicited acks.
    assign slv_rdata = {16'h3333, 16'h2222, 16'hBEEF, 16'h0F0F};
    assign slv_ack   = r_ack_q | ack_force;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_ack_q <= '0;
        else          r_ack_q <= ack_en & slv_req & ~r_ack_q;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_idle();
        host_csn = 1'b1;
        host_oen = 1'b1;
        host_wen = 1'b1;
    endtask

    initial begin
        int unsigned cnt;
        reset_n      = 1'b0;
        host_idle();
        host_address = '0;
        host_wdata   = '0;
        err_clear    = 1'b0;
        ack_en       = 4'b1011;
        ack_force    = 4'b0000;
        repeat (3) tick();

        chk("rst_req",   32'(slv_req), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_rdata", 32'(host_rdata), 32'h0);
        chk("rst_err",   32'(bus_error), 32'h0);
        chk("rst_we",    32'(slv_we), 32'h0);
        reset_n = 1'b1;
        tick();

        // Read 0x1234, slave 1 acks after one cycle.
        host_address = 16'h1234;
        host_csn = 1'b0;
        host_oen = 1'b0;
        tick();
        chk("rd_req1",  32'(slv_req), 32'h2);
        chk("rd_addr",  32'(slv_addr), 32'h234);
        chk("rd_we",    32'(slv_we), 32'h0);
        chk("rd_busy",  32'(busy), 32'h1);
        tick();
        chk("rd_req2",  32'(slv_req), 32'h2);
        tick();
        chk("rd_req3",  32'(slv_req), 32'h0);
        chk("rd_data",  32'(host_rdata), 32'hBEEF);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (slv_req != 4'b0) cnt++;
        end
        chk("rd_oneshot", cnt, 0);
        chk("rd_hold_busy", 32'(busy), 32'h1);
        host_idle();
        tick();
        chk("rd_idle", 32'(busy), 32'h0);

        // Write 0xA5A5 to 0x3010; write data only valid one cycle after wen.
        host_address = 16'h3010;
        host_wdata   = 16'hDEAD;
        host_csn = 1'b0;
        host_wen = 1'b0;
        tick();
        chk("wr_settle_req", 32'(slv_req), 32'h0);
        host_wdata = 16'hA5A5;
        tick();
        chk("wr_req",   32'(slv_req), 32'h8);
        chk("wr_we",    32'(slv_we), 32'h1);
        chk("wr_wdata", 32'(slv_wdata), 32'hA5A5);
        chk("wr_addr",  32'(slv_addr), 32'h010);
        host_idle();
        tick();
        tick();
        chk("wr_req_off",  32'(slv_req), 32'h0);
        chk("wr_rdata_hold", 32'(host_rdata), 32'hBEEF);
        tick();
        chk("wr_idle", 32'(busy), 32'h0);

        // Decode miss.
        host_address = 16'h8000;
        host_csn = 1'b0;
        host_oen = 1'b0;
        tick();
        chk("miss_req",   32'(slv_req), 32'h0);
        chk("miss_rdata", 32'(host_rdata), 32'hFFFF);
        chk("miss_err",   32'(bus_error), 32'h1);
        host_idle();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("miss_clr", 32'(bus_error), 32'h0);
        chk("miss_idle", 32'(busy), 32'h0);

        // Illegal oen+wen together, with a coincident err_clear (set wins).
        host_address = 16'h1234;
        host_csn = 1'b0;
        host_oen = 1'b0;
        host_wen = 1'b0;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("ill_err",  32'(bus_error), 32'h1);
        chk("ill_busy", 32'(busy), 32'h1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (slv_req != 4'b0) cnt++;
        end
        chk("ill_noreq", cnt, 0);
        host_idle();
        tick();
        chk("ill_idle", 32'(busy), 32'h0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Reset while in REQ on a silent slave with a stray ack on slave 0.
        ack_force = 4'b0001;
        host_address = 16'h2000;
        host_csn = 1'b0;
        host_oen = 1'b0;
        repeat (5) tick();
        chk("stray_req", 32'(slv_req), 32'h4);
        reset_n = 1'b0;
        #1;
        chk("arst_req",   32'(slv_req), 32'h0);
        chk("arst_busy",  32'(busy), 32'h0);
        chk("arst_rdata", 32'(host_rdata), 32'h0);
        host_idle();
        tick();
        reset_n = 1'b1;
        tick();
        host_address = 16'h1234;
        host_csn = 1'b0;
        host_oen = 1'b0;
        tick();
        tick();
        tick();
        chk("post_rst_data", 32'(host_rdata), 32'hBEEF);
        chk("post_rst_req",  32'(slv_req), 32'h0);
        host_idle();
        tick();

        // Slave 2 never acks.
        host_address = 16'h2000;
        host_csn = 1'b0;
        host_oen = 1'b0;
        tick();
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            if (slv_req == 4'b0) break;
            cnt++;
            tick();
        end
`ifdef GPMC_BUS_TIMEOUT_EN
        chk("tmo_cycles", cnt, 255);
        chk("tmo_rdata",  32'(host_rdata), 32'hFFFF);
        chk("tmo_err",    32'(bus_error), 32'h1);
`else
        chk("stuck_cycles", cnt, 400);
        chk("stuck_busy",   32'(busy), 32'h1);
        chk("stuck_req",    32'(slv_req), 32'h4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
